// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter (inhibit, start, 8 data
//            bits LSB first, odd parity, stop, device acknowledge).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int c_FW = $clog2(FILTER_LEN + 1);
    localparam int c_IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FW-1:0] c_FMAX = c_FW'(FILTER_LEN - 1);
    localparam logic [c_IW-1:0] c_IMAX = c_IW'(INHIBIT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Line index 0 = PS/2 clock, 1 = PS/2 data
    logic [1:0]      w_raw;
    logic [1:0]      r_s1;
    logic [1:0]      r_s2;
    logic [1:0]      r_filt;
    logic [c_FW-1:0] r_fcnt [2];
    logic            r_clk_d;
    logic            w_fall;

    assign w_raw  = {ps2_data_in, ps2_clk_in};
    assign w_fall = r_clk_d & ~r_filt[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= 2'b11;
            r_s2    <= 2'b11;
            r_filt  <= 2'b11;
            r_clk_d <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            r_s1    <= w_raw;
            r_s2    <= r_s1;
            r_clk_d <= r_filt[0];
            // A line only changes after FILTER_LEN consecutive differing samples
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == c_FMAX) begin
                    r_filt[i] <= r_s2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    state_t          r_state;
    logic [9:0]      r_frame;
    logic [3:0]      r_bitcnt;
    logic [c_IW-1:0] r_inh_cnt;
    logic [c_TW-1:0] r_to_cnt;
    logic            w_timeout;

    assign w_timeout = (r_to_cnt == c_TMAX);
    assign tx_ready  = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_bitcnt    <= '0;
            r_inh_cnt   <= '0;
            r_to_cnt    <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid) begin
                        r_frame    <= {1'b1, ~^tx_data, tx_data};
                        r_inh_cnt  <= '0;
                        ps2_clk_oe <= 1'b1;
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == c_IMAX) begin
                        ps2_data_oe <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                S_START: begin
                    ps2_clk_oe <= 1'b0;
                    r_bitcnt   <= '0;
                    r_to_cnt   <= '0;
                    r_state    <= S_SHIFT;
                end
                S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                    if (w_timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_state == S_SHIFT) begin
                            if (w_fall) begin
                                ps2_data_oe <= ~r_frame[0];
                                r_frame     <= {1'b1, r_frame[9:1]};
                                if (r_bitcnt == 4'd9) begin
                                    r_state <= S_ACK;
                                end else begin
                                    r_bitcnt <= r_bitcnt + 1'b1;
                                end
                            end
                        end else if (r_state == S_ACK) begin
                            if (w_fall) begin
                                if (!r_filt[1]) begin
                                    r_state <= S_WAIT_IDLE;
                                end else begin
                                    ps2_clk_oe  <= 1'b0;
                                    ps2_data_oe <= 1'b0;
                                    tx_err      <= 1'b1;
                                    r_state     <= S_IDLE;
                                end
                            end
                        end else if (r_filt == 2'b11) begin
                            tx_done <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Directed self-checking bench for ps2_host_tx with a PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 4000;
    localparam int FL  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic glitch_low  = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device drivers
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always @(negedge clk) begin
        if (tx_done === 1'b1) n_done++;
        if (tx_err === 1'b1) n_err++;
        if (tx_done === 1'b1 && tx_err === 1'b1) n_both++;
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic dev_wait_release(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_release: clk_oe=%b data_oe=%b, required clk_oe=0 data_oe=1",
                     name, ps2_clk_oe, ps2_data_oe);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic dev_clock(input bit glitch, output logic smp);
        dev_clk_low = 1'b1;
        repeat (50) @(negedge clk);
        smp = ps2_data_in;
        dev_clk_low = 1'b0;
        if (glitch) begin
            repeat (20) @(negedge clk);
            glitch_low = 1'b1;
            repeat (2) @(negedge clk);
            glitch_low = 1'b0;
            repeat (28) @(negedge clk);
        end else begin
            repeat (50) @(negedge clk);
        end
    endtask

    task automatic dev_frame(input bit glitch, output logic [9:0] bits);
        logic s;
        for (int i = 0; i < 10; i++) begin
            dev_clock(glitch, s);
            bits[i] = s;
        end
    endtask

    task automatic dev_ack(input bit ack);
        dev_dat_low = ack;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (50) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready: tx_ready=%b after %0d cycles, required 1", name, tx_ready, n);
        end
    endtask

    task automatic run_acked(input logic [9:0] exp, input bit glitch, input string name,
                             input int d0, input int e0);
        logic [9:0] bits;
        dev_wait_release(name);
        dev_frame(glitch, bits);
        dev_ack(1'b1);
        wait_ready(name);
        checks++;
        if (bits !== exp) begin
            failures++;
            $display("FAIL %s_bits: got %b, required %b", name, bits, exp);
        end
        checks++;
        if ((n_done - d0) !== 1) begin
            failures++;
            $display("FAIL %s_done: %0d done pulses, required 1", name, n_done - d0);
        end
        checks++;
        if ((n_err - e0) !== 0) begin
            failures++;
            $display("FAIL %s_err: %0d err pulses, required 0", name, n_err - e0);
        end
    endtask

    task automatic do_xfer(input logic [7:0] d, input logic [9:0] exp, input bit glitch,
                           input string name);
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        start_tx(d);
        run_acked(exp, glitch, name, d0, e0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_done, tx_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: clk_oe,data_oe,done,err=%b, required 0000",
                     {ps2_clk_oe, ps2_data_oe, tx_done, tx_err});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: tx_ready=%b, required 1", tx_ready);
        end
    endtask

    task automatic test_ed;
        int d0, e0, n;
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hED);
        checks++;
        if (ps2_clk_oe !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL ed_accept: clk_oe=%b ready=%b, required clk_oe=1 ready=0",
                     ps2_clk_oe, tx_ready);
        end
        n = 0;
        while (ps2_data_oe !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== INH || ps2_clk_oe !== 1'b1) begin
            failures++;
            $display("FAIL ed_inhibit: start bit after %0d cycles clk_oe=%b, required %0d clk_oe=1",
                     n, ps2_clk_oe, INH);
        end
        run_acked(10'h3ED, 1'b0, "ed", d0, e0);
    endtask

    task automatic test_parity;
        do_xfer(8'h00, 10'h300, 1'b0, "par00");
        do_xfer(8'hFF, 10'h3FF, 1'b0, "parFF");
        do_xfer(8'h01, 10'h201, 1'b0, "par01");
    endtask

    task automatic test_no_ack;
        int d0, e0;
        logic [9:0] bits;
        d0 = n_done;
        e0 = n_err;
        start_tx(8'h12);
        dev_wait_release("noack");
        dev_frame(1'b0, bits);
        dev_ack(1'b0);
        wait_ready("noack");
        checks++;
        if ((n_err - e0) !== 1 || (n_done - d0) !== 0) begin
            failures++;
            $display("FAIL noack_pulses: err=%0d done=%0d, required err=1 done=0",
                     n_err - e0, n_done - d0);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL noack_lines: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic test_timeout;
        int d0, e0, n;
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hA5);
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_err !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TMO) begin
            failures++;
            $display("FAIL timeout_cycles: err after %0d cycles, required %0d", n, TMO);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL timeout_lines: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ((n_err - e0) !== 1 || (n_done - d0) !== 0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_pulses: err=%0d done=%0d ready=%b, required 1 0 1",
                     n_err - e0, n_done - d0, tx_ready);
        end
    endtask

    task automatic test_reset_midframe;
        int d0, e0;
        logic s;
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hED);
        dev_wait_release("rstmid");
        for (int i = 0; i < 4; i++) dev_clock(1'b0, s);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (ps2_data_oe !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_bit4: data_oe=%b, required 1", ps2_data_oe);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_lines: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
        end
        @(negedge clk);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if ((n_done - d0) !== 0 || (n_err - e0) !== 0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pulses: done=%0d err=%0d ready=%b, required 0 0 1",
                     n_done - d0, n_err - e0, tx_ready);
        end
        do_xfer(8'hED, 10'h3ED, 1'b0, "rstmid_ed");
    endtask

    task automatic test_valid_held;
        int d0, e0, n;
        logic [9:0] bits;
        logic s;
        d0 = n_done;
        e0 = n_err;
        @(negedge clk);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hC3;
        dev_wait_release("held");
        for (int i = 0; i < 10; i++) begin
            tx_data = tx_data + 8'h11;
            dev_clock(1'b0, s);
            bits[i] = s;
        end
        dev_dat_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (50) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        dev_dat_low = 1'b0;
        n = 0;
        while (tx_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (bits !== 10'h35A) begin
            failures++;
            $display("FAIL held_bits: got %b, required %b", bits, 10'h35A);
        end
        checks++;
        if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
            failures++;
            $display("FAIL held_pulses: done=%0d err=%0d, required 1 0", n_done - d0, n_err - e0);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL held_single: clk_oe=%b ready=%b, required 0 1", ps2_clk_oe, tx_ready);
        end
    endtask

    task automatic test_glitch;
        do_xfer(8'h3C, 10'h33C, 1'b1, "glitch");
    endtask

    initial begin
        test_reset();
        test_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_midframe();
        test_valid_held();
        test_glitch();
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL done_err_overlap: %0d cycles with both, required 0", n_both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as ED (set LEDs) or FF (reset), from the system clock domain to the keyboard over the same two open-drain lines that the keyboard receive path listens on. It runs the full host-request sequence: inhibit, start, 8 data bits LSB first, odd parity, stop, device acknowledge. It sits beside the keyboard receiver, and the two share the PS/2 pins.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000, number of clk cycles the host holds PS/2 clock low before the start bit (≥100 µs).
- TIMEOUT_CYCLES, 750000, maximum number of clk cycles from clock release to the ack bit (15 ms).
- FILTER_LEN, 8, number of consecutive identical samples needed to update a filtered PS/2 line.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive the PS/2 clock pin low; 0 = release it.
- ps2_data_oe  out  1  1 = drive the PS/2 data pin low; 0 = release it.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  send request; sampled only while tx_ready=1.
- tx_ready  out  1  high exactly when the FSM is in IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and ack received.
- tx_err  out  1  one-cycle pulse: timeout or missing ack.

## Operation
- Each raw pin passes through a 2-flop synchronizer and then a FILTER_LEN-sample stability filter.
  - Filtered values reset to 1.
  - A falling edge of the filtered clock, fall_edge, is a single-cycle strobe.
- tx_valid && tx_ready latches tx_data and computes parity = ~^tx_data (odd parity). The frame shift register holds {1 (stop), parity, tx_data}.
- State machine:
  - IDLE: clk_oe=0, data_oe=0. On accept, go to INHIBIT and clear the counter.
  - INHIBIT: clk_oe=1. After INHIBIT_CYCLES cycles, go to START.
  - START: clk_oe=1, data_oe=1 (start bit 0) for exactly one cycle. Then go to SHIFT with clk_oe=0, the bit count at 0, and the timeout counter cleared.
  - SHIFT: on each fall_edge, set data_oe = ~frame[bitcnt] and increment bitcnt. Bits 0..7 are data, bit 8 is parity, bit 9 is stop (data released). After the 10th fall_edge, go to ACK.
  - ACK: on the next fall_edge, sample the filtered data line. If it is 0 (ack), go to WAIT_IDLE. If it is 1, pulse tx_err and go to IDLE.
  - WAIT_IDLE: wait until the filtered clock and data are both 1. Then pulse tx_done and go to IDLE.
- Timeout: the counter runs throughout SHIFT, ACK and WAIT_IDLE. If it reaches TIMEOUT_CYCLES:
  - both lines are released,
  - tx_err pulses,
  - the FSM goes to IDLE.
- A keyboard frame in progress when a request is accepted is aborted by the inhibit. This is legal PS/2 behaviour, and the receiver discards the partial frame.
- tx_valid outside IDLE is ignored; tx_data is not re-sampled.
- tx_done and tx_err never pulse in the same cycle.

## Timing
- Reset (synchronous, while reset=1):
  - FSM to IDLE, counters to 0.
  - ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0.
  - tx_ready=1 from the first cycle after reset is deasserted.
- Reset mid-frame releases both lines on the next clk edge. No done or err pulse is generated.
- All outputs are registered except tx_ready, which is decoded from the state register.
- Accept cycle N:
  - cycle N+1: ps2_clk_oe=1, tx_ready=0.
  - cycle N+1+INHIBIT_CYCLES: ps2_data_oe=1.
  - one cycle later: ps2_clk_oe=0.
- Data change latency: data_oe updates 1 cycle after fall_edge. fall_edge itself trails the pin by 2 sync cycles plus FILTER_LEN filter cycles.
- tx_done/tx_err pulse for exactly one cycle. tx_ready=1 in the cycle after the pulse.
- Timeout counter width is sized for TIMEOUT_CYCLES and saturates. There is no wrap-around.

## Test plan
Bench setup: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=4000, FILTER_LEN=4, device model clocking at a 100-cycle period.

- Send ED, device acks:
  - pins held low for 20 cycles, then start bit;
  - device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - tx_done pulses once after both lines are high; tx_err stays 0.
- Send 00: device samples parity bit 1. Send FF: device samples parity bit 1. Send 01: device samples parity bit 0.
- Device leaves data high on the 11th clock (no ack) -> tx_err pulses one cycle, FSM returns to IDLE, lines released.
- Device never clocks after start -> tx_err pulses 4000 cycles after clock release; ps2_clk_oe=0 and ps2_data_oe=0.
- Assert reset during bit 4 of a frame -> next cycle both oe=0, no done/err pulse; a following ED transfer completes normally.
- tx_valid held high through a busy transfer with tx_data changing -> exactly one frame is sent, carrying the originally latched byte. Separately, 2-cycle glitches on ps2_clk_in produce no extra bits.
